// File: rtl/i2c_pkg.sv
// Definitions shared by the I2C slave and master: FSM state encoding and R/W bit values.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    IGNORE
  } i2c_state_e;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_line_filter.sv
// Brings one asynchronous I2C line into i_clk: 2-flop synchroniser followed by a glitch filter
// that accepts a new level only after FILTER_CYCLES consecutive equal samples.
module i2c_line_filter #(
  parameter int FILTER_CYCLES = 3
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_line,
  output logic o_line
);

  localparam int CW = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(FILTER_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;

  // Down-counter restarts whenever the synchronised level agrees with the filtered one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= 2'b11;
      cnt_q  <= CNT_LOAD;
      o_line <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], i_line};
      if (sync_q[1] == o_line) begin
        cnt_q <= CNT_LOAD;
      end else if (cnt_q == '0) begin
        o_line <= sync_q[1];
        cnt_q  <= CNT_LOAD;
      end else begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C slave giving bus access to a register file that the fabric can also read and write.
// Optional pointer auto-increment after each data byte: define I2C_SLAVE_REG_AUTOINC_EN.
//
// state     | meaning
// IDLE      | bus ignored until START
// ADDR      | shifting in 7-bit address + R/W
// ADDR_ACK  | driving address ACK; read byte latched on exit
// PTR       | shifting in register pointer
// PTR_ACK   | driving pointer ACK
// WDATA     | shifting in write data
// WDATA_ACK | driving write data ACK
// RDATA     | shifting out read data MSB first
// RDATA_ACK | sampling master ACK/NACK
// IGNORE    | not addressed or NACKed; wait for START/STOP
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDRESS = 7'h42,
  parameter int         NUM_REGS      = 16,
  parameter int         FILTER_CYCLES = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_sda,
  input  logic       i_scl,
  output logic       o_sda,
  output logic       o_scl,
  input  logic [7:0] i_reg_addr,
  output logic [7:0] o_reg_rdata,
  input  logic       i_reg_we,
  input  logic [7:0] i_reg_wdata,
  output logic       o_wr_strobe,
  output logic [7:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  output logic       o_busy
);
  import i2c_pkg::*;

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic          sda_f, scl_f, sda_d, scl_d;
  logic          scl_rise, scl_fall, start_det, stop_det;
  i2c_state_e    state_q, state_nxt;
  logic [3:0]    bit_cnt_q;
  logic [7:0]    shift_q, rd_byte_q, wr_byte;
  logic [AW-1:0] ptr_q, fab_idx;
  logic [7:0]    regs_q [NUM_REGS];
  logic          ack_q, sda_nxt, in_byte, byte_done, i2c_we;
  logic          unused_addr_bits;

  i2c_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_sda_filt (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_line(i_sda), .o_line(sda_f)
  );
  i2c_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_scl_filt (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_line(i_scl), .o_line(scl_f)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sda_d <= 1'b1;
      scl_d <= 1'b1;
    end else begin
      sda_d <= sda_f;
      scl_d <= scl_f;
    end
  end

  assign scl_rise  = scl_f & ~scl_d;
  assign scl_fall  = ~scl_f & scl_d;
  assign start_det = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_det  = scl_f & scl_d & ~sda_d & sda_f;

  assign in_byte   = (state_q == ADDR) || (state_q == PTR) || (state_q == WDATA) || (state_q == RDATA);
  assign byte_done = scl_rise && (bit_cnt_q == 4'd7);
  assign wr_byte   = {shift_q[6:0], sda_f};
  assign i2c_we    = byte_done && (state_q == WDATA);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    if (stop_det) begin
      state_nxt = IDLE;
    end else if (start_det) begin
      state_nxt = ADDR;
    end else if (scl_fall) begin
      case (state_q)
        ADDR:      if (bit_cnt_q == 4'd8)
                     state_nxt = (shift_q[7:1] == SLAVE_ADDRESS) ? ADDR_ACK : IGNORE;
        ADDR_ACK:  case (shift_q[0])
                     I2C_RW_READ:  state_nxt = RDATA;
                     I2C_RW_WRITE: state_nxt = PTR;
                     default:      state_nxt = IGNORE;
                   endcase
        PTR:       if (bit_cnt_q == 4'd8) state_nxt = PTR_ACK;
        PTR_ACK:   state_nxt = WDATA;
        WDATA:     if (bit_cnt_q == 4'd8) state_nxt = WDATA_ACK;
        WDATA_ACK: state_nxt = WDATA;
        RDATA:     if (bit_cnt_q == 4'd8) state_nxt = RDATA_ACK;
        RDATA_ACK: state_nxt = ack_q ? RDATA : IGNORE;
        default:   state_nxt = state_q;
      endcase
    end
  end

  // SDA only moves on SCL falling edges, except the unconditional release on START/STOP.
  always_comb begin
    sda_nxt = o_sda;
    if (start_det || stop_det) begin
      sda_nxt = 1'b1;
    end else if (scl_fall) begin
      case (state_nxt)
        ADDR_ACK, PTR_ACK, WDATA_ACK: sda_nxt = 1'b0;
        RDATA:   sda_nxt = (state_q == RDATA) ? rd_byte_q[3'd7 - bit_cnt_q[2:0]]
                                              : regs_q[ptr_q][7];
        default: sda_nxt = 1'b1;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_sda <= 1'b1;
    else          o_sda <= sda_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rd_byte_q   <= '0;
      ack_q       <= 1'b0;
      ptr_q       <= '0;
      o_busy      <= 1'b0;
      o_wr_strobe <= 1'b0;
      o_wr_addr   <= '0;
      o_wr_data   <= '0;
    end else begin
      if (start_det || (state_nxt != state_q)) bit_cnt_q <= '0;
      else if (scl_rise && in_byte)            bit_cnt_q <= bit_cnt_q + 4'd1;

      if (scl_rise && in_byte) shift_q <= wr_byte;
      if (scl_rise && (state_q == RDATA_ACK)) ack_q <= ~sda_f;
      if (scl_fall && (state_nxt == RDATA) && (state_q != RDATA)) rd_byte_q <= regs_q[ptr_q];

      if (byte_done && (state_q == PTR)) ptr_q <= wr_byte[AW-1:0];
`ifdef I2C_SLAVE_REG_AUTOINC_EN
      else if (byte_done && ((state_q == WDATA) || (state_q == RDATA))) ptr_q <= ptr_q + AW'(1);
`endif

      if (stop_det)                                          o_busy <= 1'b0;
      else if ((state_q == ADDR) && (state_nxt == ADDR_ACK)) o_busy <= 1'b1;

      o_wr_strobe <= i2c_we;
      if (i2c_we) begin
        o_wr_addr <= 8'(ptr_q);
        o_wr_data <= wr_byte;
      end
    end
  end

  assign fab_idx          = i_reg_addr[AW-1:0];
  assign o_reg_rdata      = regs_q[fab_idx];
  assign o_scl            = 1'b1;
  assign unused_addr_bits = ^i_reg_addr;

  // A bus write to the same register in the same cycle wins over the fabric.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      if (i_reg_we && !(i2c_we && (ptr_q == fab_idx))) regs_q[fab_idx] <= i_reg_wdata;
      if (i2c_we) regs_q[ptr_q] <= wr_byte;
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Self-checking bench for i2c_slave_regfile: bus-level master tasks plus a write-strobe scoreboard.
`timescale 1ns/1ps
module tb_i2c_slave_regfile;

  localparam int Q = 12;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       m_sda = 1'b1, m_scl = 1'b1;
  logic       i_sda, i_scl, o_sda, o_scl;
  logic [7:0] i_reg_addr = '0, i_reg_wdata = '0, o_reg_rdata;
  logic       i_reg_we = 1'b0;
  logic       o_wr_strobe, o_busy;
  logic [7:0] o_wr_addr, o_wr_data;

  int          checks = 0, errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_item;
  logic        watch_sda = 1'b0, sda_low_seen = 1'b0;

  assign i_sda = m_sda & o_sda;
  assign i_scl = m_scl;

  always #5 i_clk = ~i_clk;

  i2c_slave_regfile #(.SLAVE_ADDRESS(7'h42), .NUM_REGS(16), .FILTER_CYCLES(3)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sda(i_sda), .i_scl(i_scl),
    .o_sda(o_sda), .o_scl(o_scl), .i_reg_addr(i_reg_addr), .o_reg_rdata(o_reg_rdata),
    .i_reg_we(i_reg_we), .i_reg_wdata(i_reg_wdata), .o_wr_strobe(o_wr_strobe),
    .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_busy(o_busy)
  );

  // Scoreboard monitor: every strobe must match the next expected {addr, data}.
  always @(negedge i_clk) begin
    if (o_wr_strobe === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_strobe: unexpected strobe addr=%h data=%h, none expected", o_wr_addr, o_wr_data);
      end else begin
        exp_item = exp_q.pop_front();
        if ({o_wr_addr, o_wr_data} !== exp_item) begin
          errors++;
          $display("FAIL wr_strobe: got addr=%h data=%h expected addr=%h data=%h",
                   o_wr_addr, o_wr_data, exp_item[15:8], exp_item[7:0]);
        end
      end
    end
    if (watch_sda && (o_sda !== 1'b1)) sda_low_seen = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic reg_check(input logic [7:0] a, input logic [7:0] e, input string name);
    @(negedge i_clk);
    i_reg_addr = a;
    #1;
    check(name, {24'h0, o_reg_rdata}, {24'h0, e});
  endtask

  task automatic fab_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge i_clk);
    i_reg_addr = a; i_reg_wdata = d; i_reg_we = 1'b1;
    @(negedge i_clk);
    i_reg_we = 1'b0;
  endtask

  task automatic wq();
    repeat (Q) @(negedge i_clk);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; wq(); m_scl = 1'b1; wq(); m_sda = 1'b0; wq(); m_scl = 1'b0; wq();
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wq(); m_scl = 1'b1; wq(); m_sda = 1'b1; wq();
  endtask

  task automatic put_bit(input logic b, input logic glitch);
    m_sda = b; wq(); m_scl = 1'b1;
    if (glitch) begin
      repeat (Q / 2) @(negedge i_clk);
      m_scl = 1'b0;
      @(negedge i_clk);
      m_scl = 1'b1;
    end
    wq(); wq(); m_scl = 1'b0; wq();
  endtask

  task automatic get_bit(output logic b);
    m_sda = 1'b1; wq(); m_scl = 1'b1; wq(); b = i_sda; wq(); m_scl = 1'b0; wq();
  endtask

  task automatic put_byte(input logic [7:0] d, input int glitch_bit, output logic ack);
    logic nb;
    for (int i = 7; i >= 0; i--) put_bit(d[i], i == glitch_bit);
    get_bit(nb);
    ack = ~nb;
  endtask

  task automatic get_byte(output logic [7:0] d, input logic ack);
    logic b;
    d = '0;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d = {d[6:0], b};
    end
    put_bit(~ack, 1'b0);
  endtask

  logic       ack;
  logic [7:0] rb;
  logic       bt;
  logic [3:0] nib;

  initial begin
    repeat (3) @(negedge i_clk);
    check("rst_sda", o_sda, 1);
    check("rst_scl", o_scl, 1);
    check("rst_busy", o_busy, 0);
    check("rst_strobe", o_wr_strobe, 0);
    check("rst_wr_addr", o_wr_addr, 0);
    check("rst_wr_data", o_wr_data, 0);
    reg_check(8'h03, 8'h00, "rst_reg3");
    i_rst_n = 1'b1;
    wq();

    // Write 0xA5 to register 3
    exp_q.push_back({8'h03, 8'hA5});
    bus_start();
    put_byte(8'h84, -1, ack); check("wr_addr_ack", ack, 1);
    check("wr_busy", o_busy, 1);
    put_byte(8'h03, -1, ack); check("wr_ptr_ack", ack, 1);
    put_byte(8'hA5, -1, ack); check("wr_data_ack", ack, 1);
    bus_stop(); wq();
    check("wr_busy_after_stop", o_busy, 0);
    reg_check(8'h03, 8'hA5, "wr_reg3");

    // Combined read: pointer write, repeated START, read with NACK
    bus_start();
    put_byte(8'h84, -1, ack); check("rd_addr_w_ack", ack, 1);
    put_byte(8'h03, -1, ack); check("rd_ptr_ack", ack, 1);
    bus_start();
    put_byte(8'h85, -1, ack); check("rd_addr_r_ack", ack, 1);
    get_byte(rb, 1'b0);
    check("rd_data", {24'h0, rb}, 32'h0000_00A5);
    check("rd_busy", o_busy, 1);
    bus_stop(); wq();
    check("rd_busy_after_stop", o_busy, 0);

    // Wrong address: NACKed, SDA never driven
    sda_low_seen = 1'b0; watch_sda = 1'b1;
    bus_start();
    put_byte(8'h90, -1, ack); check("na_addr_nack", ack, 0);
    put_byte(8'h00, -1, ack); check("na_data_nack", ack, 0);
    bus_stop(); wq();
    watch_sda = 1'b0;
    check("na_sda_low", sda_low_seen, 0);
    check("na_busy", o_busy, 0);
    reg_check(8'h00, 8'h00, "na_reg0");
    reg_check(8'h03, 8'hA5, "na_reg3");

    // Fabric access, address taken modulo NUM_REGS
    fab_write(8'h17, 8'h5A);
    reg_check(8'h07, 8'h5A, "fab_reg7");
    reg_check(8'h27, 8'h5A, "fab_alias");

    // One-cycle SCL low glitch while bit 3 of a data byte is high
    exp_q.push_back({8'h05, 8'h3C});
    bus_start();
    put_byte(8'h84, -1, ack);
    put_byte(8'h05, -1, ack);
    put_byte(8'h3C, 3, ack); check("gl_data_ack", ack, 1);
    bus_stop(); wq();
    reg_check(8'h05, 8'h3C, "gl_reg5");
    reg_check(8'h06, 8'h00, "gl_reg6");

    // Pointer 0x0F followed by two data bytes
`ifdef I2C_SLAVE_REG_AUTOINC_EN
    exp_q.push_back({8'h0F, 8'h11});
    exp_q.push_back({8'h00, 8'h22});
`else
    exp_q.push_back({8'h0F, 8'h11});
    exp_q.push_back({8'h0F, 8'h22});
`endif
    bus_start();
    put_byte(8'h84, -1, ack);
    put_byte(8'h0F, -1, ack);
    put_byte(8'h11, -1, ack); check("pw_d1_ack", ack, 1);
    put_byte(8'h22, -1, ack); check("pw_d2_ack", ack, 1);
    bus_stop(); wq();
`ifdef I2C_SLAVE_REG_AUTOINC_EN
    reg_check(8'h0F, 8'h11, "pw_reg15");
    reg_check(8'h00, 8'h22, "pw_reg0");
`else
    reg_check(8'h0F, 8'h22, "pw_reg15");
    reg_check(8'h00, 8'h00, "pw_reg0");
`endif

    // Reset after the 4th bit of a read byte (0xA5: next bit driven is 0)
    bus_start();
    put_byte(8'h84, -1, ack);
    put_byte(8'h03, -1, ack);
    bus_start();
    put_byte(8'h85, -1, ack);
    nib = '0;
    for (int i = 0; i < 4; i++) begin
      get_bit(bt);
      nib = {nib[2:0], bt};
    end
    check("rr_nibble", {28'h0, nib}, 32'h0000_000A);
    check("rr_sda_before", o_sda, 0);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    check("rr_sda_released", o_sda, 1);
    check("rr_busy", o_busy, 0);
    reg_check(8'h03, 8'h00, "rr_reg3");
    reg_check(8'h05, 8'h00, "rr_reg5");
    i_rst_n = 1'b1;
    wq();
    bus_stop(); wq();

    // Operation resumes after reset
    exp_q.push_back({8'h02, 8'h77});
    bus_start();
    put_byte(8'h84, -1, ack); check("post_addr_ack", ack, 1);
    put_byte(8'h02, -1, ack);
    put_byte(8'h77, -1, ack); check("post_data_ack", ack, 1);
    bus_stop(); wq();
    reg_check(8'h02, 8'h77, "post_reg2");

    check("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
